// File: rtl/sram_pkg.sv
// Shared SRAM geometry and the readback transmitter state encoding.
package sram_pkg;

  localparam int ROWS = 16;
  localparam int COLS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } tx_state_t;

endpackage

// File: rtl/sram_word_fifo.sv
// Small synchronous word FIFO; a pop from a full FIFO frees a slot for a push in the same cycle.
module sram_word_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == {CNT_W{1'b0}});
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/sram_serial_tx.sv
// Readback transmitter: buffers SRAM read words and streams each one MSB-first
// on serial_out, each bit held BIT_CYCLES clocks, followed by a one-cycle gap.
module sram_serial_tx #(
  parameter int COLS       = sram_pkg::COLS,
  parameter int BIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic            data_valid,
  input  logic [COLS-1:0] data_out,
  input  logic            hold,
  input  logic            clr_ovf,
  output logic            serial_out,
  output logic            shift_out,
  output logic            frame_start,
  output logic            busy,
  output logic            overflow
);

  import sram_pkg::*;

  localparam int BIT_W = $clog2(COLS + 1);
  localparam int CYC_W = $clog2(BIT_CYCLES + 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(COLS - 1);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);

  tx_state_t         state_q, state_d;
  logic [COLS-1:0]   sreg_q, sreg_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CYC_W-1:0]  cyc_cnt_q, cyc_cnt_d;
  logic              stall_q, stall_d;
  logic              serial_out_q, serial_out_d;
  logic              shift_out_q, shift_out_d;
  logic              frame_start_q, frame_start_d;
  logic              busy_q, busy_d;
  logic              overflow_q, overflow_d;

  logic              pop;
  logic              push_acc;
  logic              drop;
  logic [COLS-1:0]   fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;

  sram_word_fifo #(
    .WIDTH (COLS),
    .DEPTH (2)
  ) u_fifo (
    .clk   (clk),
    .rst_n (arst_n),
    .push  (data_valid),
    .pop   (pop),
    .din   (data_out),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign push_acc = data_valid && (!fifo_full || pop);
  assign drop     = data_valid && fifo_full && !pop;

  // Outputs are computed from the next state so they appear registered, one edge after the decision.
  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    bit_cnt_d = bit_cnt_q;
    cyc_cnt_d = cyc_cnt_q;
    stall_d   = stall_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && !hold) begin
          pop       = 1'b1;
          sreg_d    = fifo_dout;
          bit_cnt_d = {BIT_W{1'b0}};
          cyc_cnt_d = {CYC_W{1'b0}};
          stall_d   = 1'b0;
          state_d   = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (stall_q) begin
          stall_d = hold;
        end else if (cyc_cnt_q == CYC_LAST) begin
          sreg_d    = sreg_q << 1;
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          cyc_cnt_d = {CYC_W{1'b0}};
          if (bit_cnt_q == BIT_LAST) begin
            state_d = GAP;
          end else begin
            stall_d = hold;
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    shift_out_d   = (state_d == SHIFT) && !stall_d;
    serial_out_d  = shift_out_d ? sreg_d[COLS-1] : serial_out_q;
    frame_start_d = pop;
    busy_d        = (state_d != IDLE) || !fifo_empty || push_acc;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q       <= IDLE;
      sreg_q        <= {COLS{1'b0}};
      bit_cnt_q     <= {BIT_W{1'b0}};
      cyc_cnt_q     <= {CYC_W{1'b0}};
      stall_q       <= 1'b0;
      serial_out_q  <= 1'b0;
      shift_out_q   <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      sreg_q        <= sreg_d;
      bit_cnt_q     <= bit_cnt_d;
      cyc_cnt_q     <= cyc_cnt_d;
      stall_q       <= stall_d;
      serial_out_q  <= serial_out_d;
      shift_out_q   <= shift_out_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
      overflow_q    <= overflow_d;
    end
  end

  assign serial_out  = serial_out_q;
  assign shift_out   = shift_out_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_sram_serial_tx.sv
// Scoreboard bench for sram_serial_tx: stimulus queues expected words, a negedge
// monitor deserialises every frame and compares it against the queue head.
module tb_sram_serial_tx;

  localparam int COLS = 8;
  localparam int BC   = 2;
  localparam int NS   = COLS * BC;

  logic            clk;
  logic            arst_n;
  logic            data_valid;
  logic [COLS-1:0] data_out;
  logic            hold;
  logic            clr_ovf;
  logic            serial_out;
  logic            shift_out;
  logic            frame_start;
  logic            busy;
  logic            overflow;

  int n_vec = 0;
  int n_bad = 0;
  logic [COLS-1:0] exp_q [$];

  sram_serial_tx #(
    .COLS       (COLS),
    .BIT_CYCLES (BC)
  ) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .data_valid  (data_valid),
    .data_out    (data_out),
    .hold        (hold),
    .clr_ovf     (clr_ovf),
    .serial_out  (serial_out),
    .shift_out   (shift_out),
    .frame_start (frame_start),
    .busy        (busy),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [COLS-1:0] w, input bit accept);
    data_valid = 1'b1;
    data_out   = w;
    if (accept) exp_q.push_back(w);
    tick();
    data_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 300) begin
      tick();
      n++;
    end
    check({name, " idle"}, 32'(busy), 32'd0);
    tick();
    check({name, " drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: collect NS samples per frame, rebuild the word, check bit hold and gap.
  logic samp [NS];
  int   nsamp = 0;
  bit   collecting = 1'b0;
  bit   gap_pending = 1'b0;

  always @(negedge clk) begin
    logic [COLS-1:0] word;
    logic [COLS-1:0] exp_w;
    bit held_ok;
    if (arst_n !== 1'b1) begin
      collecting  = 1'b0;
      gap_pending = 1'b0;
      nsamp       = 0;
    end else begin
      if (gap_pending) begin
        check("gap cycle shift_out", 32'(shift_out), 32'd0);
        gap_pending = 1'b0;
      end
      if (frame_start === 1'b1) begin
        check("frame_start inside frame", 32'(collecting), 32'd0);
        check("frame_start with shift_out", 32'(shift_out), 32'd1);
        collecting = 1'b1;
        nsamp      = 0;
      end
      if (shift_out === 1'b1 && collecting) begin
        samp[nsamp] = serial_out;
        nsamp++;
        if (nsamp == NS) begin
          word    = {COLS{1'b0}};
          held_ok = 1'b1;
          for (int i = 0; i < COLS; i++) begin
            word = {word[COLS-2:0], samp[i*BC]};
            if (samp[i*BC+1] !== samp[i*BC]) held_ok = 1'b0;
          end
          check("bit held full period", 32'(held_ok), 32'd1);
          if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected frame: got %02h expected none", word);
          end else begin
            exp_w = exp_q.pop_front();
            check("frame word", 32'(word), 32'(exp_w));
          end
          collecting  = 1'b0;
          gap_pending = 1'b1;
        end
      end else if (shift_out === 1'b1) begin
        check("shift_out outside frame", 32'(shift_out), 32'd0);
      end
    end
  end

  initial begin
    arst_n     = 1'b0;
    data_valid = 1'b0;
    data_out   = 8'h00;
    hold       = 1'b0;
    clr_ovf    = 1'b0;
    repeat (3) tick();
    arst_n = 1'b1;
    check("reset serial_out", 32'(serial_out), 32'd0);
    check("reset shift_out", 32'(shift_out), 32'd0);
    check("reset frame_start", 32'(frame_start), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset overflow", 32'(overflow), 32'd0);
    tick();

    // A5: latency, framing and busy fall after the gap.
    send(8'hA5, 1'b1);
    check("a5 c1 frame_start", 32'(frame_start), 32'd0);
    check("a5 c1 busy", 32'(busy), 32'd1);
    tick();
    check("a5 c2 frame_start", 32'(frame_start), 32'd1);
    check("a5 c2 shift_out", 32'(shift_out), 32'd1);
    check("a5 c2 msb", 32'(serial_out), 32'd1);
    tick();
    check("a5 c3 frame_start", 32'(frame_start), 32'd0);
    repeat (14) tick();
    check("a5 c17 shift_out", 32'(shift_out), 32'd1);
    check("a5 c17 lsb", 32'(serial_out), 32'd1);
    tick();
    check("a5 c18 shift_out", 32'(shift_out), 32'd0);
    check("a5 c18 busy", 32'(busy), 32'd1);
    tick();
    check("a5 c19 busy", 32'(busy), 32'd0);
    wait_idle("a5");

    // FF then 00 one cycle apart.
    send(8'hFF, 1'b1);
    tick();
    send(8'h00, 1'b1);
    wait_idle("ff00");
    check("ff00 overflow", 32'(overflow), 32'd0);

    // Three words in consecutive cycles.
    send(8'h3C, 1'b1);
    send(8'h81, 1'b1);
    send(8'h7E, 1'b1);
    wait_idle("three");
    check("three overflow", 32'(overflow), 32'd0);

    // Overflow: fill mid-frame, drop, clear, then set-beats-clear.
    send(8'h96, 1'b1);
    repeat (3) tick();
    send(8'h0F, 1'b1);
    send(8'hF0, 1'b1);
    send(8'h55, 1'b0);
    check("ovf set", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("ovf cleared", 32'(overflow), 32'd0);
    clr_ovf = 1'b1;
    send(8'hAA, 1'b0);
    clr_ovf = 1'b0;
    check("ovf set wins over clear", 32'(overflow), 32'd1);
    wait_idle("ovf");

    // Hold during bit 3 of C3.
    send(8'hC3, 1'b1);
    repeat (7) tick();
    hold = 1'b1;
    tick();
    check("hold bit3 completes", 32'(shift_out), 32'd1);
    tick();
    check("hold frozen shift_out", 32'(shift_out), 32'd0);
    check("hold frozen serial_out", 32'(serial_out), 32'd0);
    repeat (4) tick();
    hold = 1'b0;
    check("hold still frozen", 32'(shift_out), 32'd0);
    tick();
    check("hold resumed", 32'(shift_out), 32'd1);
    wait_idle("hold");
    check("overflow sticky", 32'(overflow), 32'd1);

    // Reset during bit 5 with a word queued.
    send(8'h5A, 1'b1);
    tick();
    send(8'h99, 1'b1);
    repeat (9) tick();
    arst_n = 1'b0;
    exp_q.delete();
    tick();
    arst_n = 1'b1;
    check("midreset serial_out", 32'(serial_out), 32'd0);
    check("midreset shift_out", 32'(shift_out), 32'd0);
    check("midreset frame_start", 32'(frame_start), 32'd0);
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset overflow", 32'(overflow), 32'd0);
    repeat (40) tick();
    check("post reset busy", 32'(busy), 32'd0);
    check("post reset shift_out", 32'(shift_out), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_serial_tx.md
# sram_serial_tx

Parallel-to-serial readback transmitter for the mixed-signal SRAM. It captures each read word from the SRAM digital frontend when `data_valid` pulses. It then streams the word out MSB-first on a single wire, using the same bit framing the write path accepts on its serial input. It sits between the SRAM top and the off-chip/test pin, and buffers up to two read words so back-to-back reads are not lost.

## Interface
Parameters:
- `COLS`, 8: word width; matches SRAM column count.
- `BIT_CYCLES`, 2: clock cycles each bit is held on `serial_out`; must be ≥ 1.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `arst_n`  in  1  reset; synchronous, active-low.
- `data_valid`  in  1  one-cycle strobe: `data_out` holds a valid read word.
- `data_out`  in  COLS  read word from the SRAM frontend.
- `hold`  in  1  downstream stall request, honoured only at bit boundaries.
- `clr_ovf`  in  1  clears `overflow`.
- `serial_out`  out  1  current bit, MSB first.
- `shift_out`  out  1  high while `serial_out` carries a valid bit.
- `frame_start`  out  1  one-cycle pulse on the first cycle of each word's MSB.
- `busy`  out  1  high when the FSM is not IDLE or the FIFO is non-empty.
- `overflow`  out  1  sticky: a word was dropped because the FIFO was full.

## Operation
- 2-entry word FIFO.
  - Push on `data_valid` when not full.
  - When full, a push drops the incoming word and sets `overflow`.
  - Push and pop in the same cycle while full: the pop frees the slot and the push is accepted; no overflow.
- FSM states are IDLE, SHIFT and GAP.
- IDLE:
  - If the FIFO is non-empty, pop the head into the shift register, clear the bit and hold counters, and go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT:
  - `shift_out`=1 and `serial_out`=`sreg[COLS-1]`.
  - `cyc_cnt` counts 0..BIT_CYCLES-1.
  - At `cyc_cnt`=BIT_CYCLES-1 the shift register shifts left by one, `bit_cnt` increments, and `cyc_cnt` returns to 0.
  - After bit COLS-1 completes, go to GAP.
- GAP:
  - Exactly one cycle with `shift_out`=0, then go to IDLE.
  - IDLE re-evaluates the FIFO on the next cycle.
- `hold`:
  - Sampled only on the last cycle of a bit (`cyc_cnt`=BIT_CYCLES-1) or at the IDLE pop decision.
  - While it is honoured, the counters freeze, `shift_out`=0, and `serial_out` keeps its last value.
  - Shifting resumes on the cycle after `hold` deasserts.
  - `hold` never truncates a bit mid-period.
- `overflow`:
  - Set on a dropped push.
  - Cleared by `clr_ovf`.
  - If set and clear occur in the same cycle, set wins.
- Bit counter width is $clog2(COLS+1). Cycle counter width is $clog2(BIT_CYCLES+1).

## Timing
- Reset values (`arst_n`=0 at an edge):
  - FSM in IDLE and FIFO empty.
  - `serial_out`=0, `shift_out`=0, `frame_start`=0, `busy`=0, `overflow`=0.
- Reset mid-word aborts the word and flushes the FIFO. There is no partial output after reset.
- Latency, with the FIFO empty and the FSM idle:
  - `data_valid` high in cycle 0 means the word is in the FIFO after edge 0.
  - IDLE pops at edge 1.
  - The MSB is on `serial_out`, with `shift_out`=1 and `frame_start`=1, in cycle 2.
- A word occupies COLS×BIT_CYCLES SHIFT cycles plus 1 GAP cycle. With the defaults that is 17 cycles, plus 1 IDLE cycle before the next word.
- All outputs are registered.

## Structure
- Shared package `sram_pkg`:
  - `ROWS` and `COLS` constants.
  - `tx_state_t` enum (IDLE, SHIFT, GAP).
- Sub-module `sram_word_fifo`, parameterised by width and depth (depth 2 here).
  - Ports: `push`, `pop`, `din`, `dout`, `full`, `empty`.
  - It also serves later write-side buffering.

## Test plan
- Reset, then `data_out`=8'hA5 with one `data_valid` → frame bits 1,0,1,0,0,1,0,1, each bit held 2 cycles.
  - `frame_start` in cycle 2.
  - `shift_out` low after 16 cycles.
  - `busy` falls after the GAP cycle.
- Back-to-back 8'hFF, 8'h00, one cycle apart → both words transmitted in order, GAP+IDLE between them, `overflow`=0.
- Three words in consecutive cycles while idle → first popped at edge 1 and the next two buffered, so all three are sent and `overflow` stays 0.
- Fill the FIFO mid-frame, then push a fourth word → word dropped and `overflow`=1.
  - Pulsing `clr_ovf` returns `overflow` to 0.
  - The remaining words are intact.
- `hold` asserted during bit 3 of 8'hC3 → bit 3 completes its 2 cycles, then output freezes with `shift_out`=0.
  - After `hold` is released, bits 4..7 continue with no bits lost.
- `arst_n` low for one cycle during bit 5 of a word with one word queued → all outputs return to their reset values, the FIFO is empty, and there is no further frame.
